sdram_req_arbiter: RTL
======================

Name: sdram_req_arbiter

Overview:
- Sequences the single-port 8-bit SDRAM controller for the SNES core.
- Shares that controller between NUM_PORTS requesters: CPU/ROM fetch, PPU VRAM, APU, and the SD loader.
- Owns refresh scheduling, so requesters never see refresh timing. Refresh is issued from an interval counter with a bounded debt.
- Sits in the core_clk / sdram command domain between the requesters and the controller's write/read/adrs/din/dout/refresh/ack interface.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- ADRS_W, 23, byte address width.
- REFRESH_CYCLES, 390, clocks between refresh credits (7.8 us at 50 MHz).
- REFRESH_URGENT, 2, pending-refresh count at which refresh preempts requesters.
- TIMEOUT_CYCLES, 255, ack watchdog limit (used only with the optional feature).

Ports:
- m_clock  in  1  sole clock.
- p_reset_n  in  1  asynchronous, active-low reset.
- req_read  in  NUM_PORTS  per-port read request; level, held until ack.
- req_write  in  NUM_PORTS  per-port write request; level, held until ack.
- req_adrs  in  NUM_PORTS*ADRS_W  packed addresses; port i at [i*ADRS_W +: ADRS_W].
- req_din  in  NUM_PORTS*8  packed write data.
- req_ack  out  NUM_PORTS  one-cycle completion pulse per port.
- req_dout  out  8  read data; valid in the ack cycle, held until the next read completes.
- mem_read  out  1  one-cycle read command to the controller.
- mem_write  out  1  one-cycle write command to the controller.
- mem_adrs  out  ADRS_W  latched address.
- mem_din  out  8  latched write data.
- mem_dout  in  8  controller read data; valid when mem_ack=1.
- mem_refresh  out  1  one-cycle auto-refresh command.
- mem_ack  in  1  controller completion pulse for read, write, or refresh.
- busy  out  1  high whenever the FSM is not in IDLE.
- refresh_debt  out  3  pending refresh count (debug).
- err_timeout  out  1  sticky watchdog flag; 0 unless ARB_TIMEOUT_EN is defined.

Behaviour:
- Reset state: all outputs 0; FSM=IDLE; round-robin pointer=0; refresh timer=0; debt=0.
- Refresh timer counts 0..REFRESH_CYCLES-1 and wraps.
  - On wrap, debt increments, saturating at 7.
  - When debt is 7 and a wrap occurs, the credit is dropped. Debt never wraps.
- A request on port i is req_read[i] | req_write[i].
  - If both are set, write wins; the read stays pending and is served as a later, separate transaction.
- IDLE arbitration, evaluated every cycle, in priority order:
  - (a) debt >= REFRESH_URGENT -> REFRESH.
  - (b) any request -> grant the first requesting port at or after the RR pointer (cyclic) -> ISSUE.
  - (c) debt > 0 and no requests -> REFRESH.
  - (d) otherwise stay in IDLE.
- On grant, latch adrs, din, op, and port index.
- ISSUE (1 cycle): pulse mem_read or mem_write; drive mem_adrs/mem_din from the latch (stable until the ack) -> WAIT.
- WAIT: hold until mem_ack.
  - Then pulse req_ack[granted] for 1 cycle; on a read, register mem_dout into req_dout.
  - Set RR pointer = granted+1 mod NUM_PORTS -> IDLE.
  - Minimum grant-to-ack latency: 2 cycles plus controller latency.
  - Back-to-back service: a new grant is possible the cycle after the ack.
- REFRESH: pulse mem_refresh for 1 cycle, then wait for mem_ack; on ack, debt -= 1 -> IDLE.
  - A timer wrap in the same cycle as the decrement leaves debt unchanged.
- mem_ack outside WAIT or refresh-wait is ignored.
- Requester-side rules:
  - A requester must keep its request and data stable until its ack.
  - Dropping a request after grant does not cancel the transaction; it completes and is acked.
- Reset mid-transaction returns to the reset state immediately; no ack is emitted.
- Command exclusivity: at most one of mem_read, mem_write, mem_refresh is high in any cycle.
- Outstanding transactions: never more than one.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: a WAIT or refresh-wait lasting TIMEOUT_CYCLES without mem_ack does the following:
  - sets err_timeout (sticky until reset);
  - returns to IDLE;
  - for a port transaction, pulses req_ack[granted] with req_dout=8'hFF (reads only) and advances the RR pointer;
  - for a refresh, still decrements debt.
- Not defined: no watchdog counter exists, err_timeout is tied to 0, and WAIT can last indefinitely.

Test Plan:
- Single read: port 2 reads adrs 0x012345; mem_dout=0xA5 with ack 3 cycles after mem_read -> exactly one mem_read pulse with mem_adrs=0x012345, req_ack[2] pulses once, req_dout=0xA5.
- Round-robin fairness: all 4 ports hold writes; controller acks each after 1 cycle -> grant order 0,1,2,3,0, and mem_din matches each port's data.
- Refresh: no requests, REFRESH_CYCLES=16 -> mem_refresh pulse after 16 cycles, debt returns to 0 after the ack.
- Urgent refresh: port 0 requests continuously and the controller stalls acks for 40 cycles (REFRESH_CYCLES=16) -> debt reaches 2, and the next IDLE issues mem_refresh ahead of port 0.
- Conflict and reset: port 1 asserts read and write together -> write served first, then the read. Then assert p_reset_n low during WAIT -> all outputs 0 asynchronously and no req_ack.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10: read with mem_ack never asserted -> err_timeout=1, req_ack pulses with req_dout=0xFF, and the next port is served.

Source files
------------

// File: rtl/sdram_req_arbiter_if.sv
// Requester and SDRAM-controller bundle for sdram_req_arbiter.
// master = arbiter side, slave = requesters plus controller.
interface sdram_req_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADRS_W    = 23
);
  logic [NUM_PORTS-1:0]        req_read;
  logic [NUM_PORTS-1:0]        req_write;
  logic [NUM_PORTS*ADRS_W-1:0] req_adrs;
  logic [NUM_PORTS*8-1:0]      req_din;
  logic [NUM_PORTS-1:0]        req_ack;
  logic [7:0]                  req_dout;
  logic                        mem_read;
  logic                        mem_write;
  logic [ADRS_W-1:0]           mem_adrs;
  logic [7:0]                  mem_din;
  logic [7:0]                  mem_dout;
  logic                        mem_refresh;
  logic                        mem_ack;

  modport master (
    input  req_read, req_write, req_adrs, req_din,
    input  mem_dout, mem_ack,
    output req_ack, req_dout,
    output mem_read, mem_write, mem_adrs, mem_din,
    output mem_refresh
  );

  modport slave (
    output req_read, req_write, req_adrs, req_din,
    output mem_dout, mem_ack,
    input  req_ack, req_dout,
    input  mem_read, mem_write, mem_adrs, mem_din,
    input  mem_refresh
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// Round-robin SDRAM request arbiter with built-in refresh scheduling.
// Define ARB_TIMEOUT_EN to add the mem_ack watchdog and err_timeout.
module sdram_req_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int ADRS_W         = 23,
  parameter int REFRESH_CYCLES = 390,
  parameter int REFRESH_URGENT = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                m_clock,
  input  logic                p_reset_n,
  sdram_req_arbiter_if.master bus,
  output logic                busy,
  output logic [2:0]          refresh_debt,
  output logic                err_timeout
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int TW = $clog2(REFRESH_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_REF,
    S_RWAIT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [PW-1:0]        r_rr;
  logic [PW-1:0]        r_port;
  logic [PW-1:0]        w_gnt;
  logic                 w_any;
  logic                 w_grant;
  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] r_ack;
  logic                 r_wr;
  logic [ADRS_W-1:0]    r_adrs;
  logic [7:0]           r_din;
  logic [7:0]           r_dout;
  logic [TW-1:0]        r_timer;
  logic [2:0]           r_debt;
  logic                 w_wrap;
  logic                 w_to;
  logic                 w_done;
  logic                 w_dec;
  logic [ADRS_W-1:0]    w_sel_adrs;
  logic [7:0]           w_sel_din;
  logic                 w_sel_wr;

  // Mask the port being acked: it still holds its request this cycle.
  assign w_req = (bus.req_read | bus.req_write) & ~r_ack;
  assign w_wrap = (r_timer == TW'(REFRESH_CYCLES - 1));

  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      int j;
      j = int'(r_rr) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!w_any && w_req[PW'(j)]) begin
        w_any = 1'b1;
        w_gnt = PW'(j);
      end
    end
  end

  always_comb begin
    w_sel_adrs = '0;
    w_sel_din  = '0;
    w_sel_wr   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PW'(i) == w_gnt) begin
        w_sel_adrs = bus.req_adrs[i*ADRS_W +: ADRS_W];
        w_sel_din  = bus.req_din[i*8 +: 8];
        w_sel_wr   = bus.req_write[i];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wdog;
  logic          r_err;
  logic          w_waiting;

  assign w_waiting = (r_state == S_WAIT) ||
                     (r_state == S_RWAIT);
  assign w_to = w_waiting && !bus.mem_ack &&
                (r_wdog == WW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = r_err;

  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_waiting && !bus.mem_ack && !w_to)
        r_wdog <= r_wdog + 1'b1;
      else
        r_wdog <= '0;
      if (w_to)
        r_err <= 1'b1;
    end
  end
`else
  assign w_to = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign w_done = (r_state == S_WAIT) &&
                  (bus.mem_ack || w_to);
  assign w_dec  = (r_state == S_RWAIT) &&
                  (bus.mem_ack || w_to);

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_debt >= 3'(REFRESH_URGENT)) begin
          w_next = S_REF;
        end else if (w_any) begin
          w_next  = S_ISSUE;
          w_grant = 1'b1;
        end else if (r_debt != 3'd0) begin
          w_next = S_REF;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_done) w_next = S_IDLE;
      S_REF:   w_next = S_RWAIT;
      S_RWAIT: if (w_dec) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_port  <= '0;
      r_ack   <= '0;
      r_wr    <= 1'b0;
      r_adrs  <= '0;
      r_din   <= '0;
      r_dout  <= '0;
      r_timer <= '0;
      r_debt  <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= w_wrap ? '0 : r_timer + 1'b1;
      // Credit and payback in the same cycle cancel out.
      if (w_wrap && !w_dec && r_debt != 3'd7)
        r_debt <= r_debt + 3'd1;
      else if (w_dec && !w_wrap)
        r_debt <= r_debt - 3'd1;
      r_ack <= '0;
      if (w_grant) begin
        r_port <= w_gnt;
        r_wr   <= w_sel_wr;
        r_adrs <= w_sel_adrs;
        r_din  <= w_sel_din;
      end
      if (w_done) begin
        r_ack[r_port] <= 1'b1;
        r_rr <= (r_port == PW'(NUM_PORTS - 1)) ?
                '0 : r_port + 1'b1;
        if (!r_wr)
          r_dout <= bus.mem_ack ? bus.mem_dout : 8'hFF;
      end
    end
  end

  assign bus.mem_read    = (r_state == S_ISSUE) && !r_wr;
  assign bus.mem_write   = (r_state == S_ISSUE) && r_wr;
  assign bus.mem_refresh = (r_state == S_REF);
  assign bus.mem_adrs    = r_adrs;
  assign bus.mem_din     = r_din;
  assign bus.req_ack     = r_ack;
  assign bus.req_dout    = r_dout;
  assign busy            = (r_state != S_IDLE);
  assign refresh_debt    = r_debt;
endmodule
